// File: rtl/com_frame_loader_if.sv
// com_frame_loader_if
//   Bundles the two streams around the frame loader:
//     host side : host_data/host_valid/host_last in, host_ready out
//     core side : com_data_in/data_write_start/data_write_done out,
//                 output_write_done in
//   modport slave  : the loader itself
//   modport master : the environment (host plus downstream core)
interface com_frame_loader_if;
    logic [15:0] host_data;
    logic        host_valid;
    logic        host_last;
    logic        host_ready;
    logic [15:0] com_data_in;
    logic        data_write_start;
    logic        data_write_done;
    logic        output_write_done;

    modport master (
        output host_data, host_valid, host_last, output_write_done,
        input  host_ready, com_data_in, data_write_start, data_write_done
    );

    modport slave (
        input  host_data, host_valid, host_last, output_write_done,
        output host_ready, com_data_in, data_write_start, data_write_done
    );
endinterface

// File: rtl/com_frame_loader.sv
// com_frame_loader
//   Buffers one frame of 16-bit host words, then replays it to the core one
//   word per cycle without gaps, then holds data_write_done until the core
//   reports output_write_done.
//
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     bus         : com_frame_loader_if.slave (host stream + core load port)
//     word_count  : words in the current frame
//     overflow    : sticky, frame was truncated at DEPTH
//     ld_state    : IDLE=00 FILL=01 STREAM=10 WAIT=11
//     checksum    : mod-2^16 sum of the frame's words
//
//   Optional feature macro: LOADER_CHECKSUM_EN (checksum is tied to 0 when
//   the macro is undefined).
//
//   state  | meaning
//   IDLE   | empty, waiting for the first word of a frame
//   FILL   | accepting words into the buffer
//   STREAM | replaying buffer[0..N-1] to the core
//   WAIT   | frame delivered, waiting for output_write_done
module com_frame_loader #(
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    com_frame_loader_if.slave          bus,
    output logic [$clog2(DEPTH+1)-1:0] word_count,
    output logic                       overflow,
    output logic [1:0]                 ld_state,
    output logic [15:0]                checksum
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FILL   = 2'b01,
        STREAM = 2'b10,
        WAIT   = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem [DEPTH];
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] count_inc;
    logic          accept, first_word, rd_en, stream_end, release_frame;

    assign count_inc      = word_count + 1'b1;
    assign bus.host_ready = ((state_q == IDLE) || (state_q == FILL)) && (word_count < FULL);
    assign accept         = bus.host_valid && bus.host_ready;
    assign ld_state       = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        first_word    = 1'b0;
        rd_en         = 1'b0;
        stream_end    = 1'b0;
        release_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    first_word = 1'b1;
                    state_d    = bus.host_last ? STREAM : FILL;
                end
            end
            FILL: begin
                if (accept && (bus.host_last || (count_inc == FULL))) state_d = STREAM;
            end
            STREAM: begin
                // One extra cycle after the last read lets the registered
                // read data reach the core before the state says WAIT.
                if (rd_ptr == word_count) begin
                    stream_end = 1'b1;
                    state_d    = WAIT;
                end else begin
                    rd_en = 1'b1;
                end
            end
            WAIT: begin
                if (bus.output_write_done) begin
                    release_frame = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer write port; word_count doubles as the write pointer.
    always_ff @(posedge clk) begin
        if (accept) mem[word_count[AW-1:0]] <= bus.host_data;
    end

    // Registered read port; its output register is the core data output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     bus.com_data_in <= '0;
        else if (rd_en) bus.com_data_in <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count           <= '0;
            rd_ptr               <= '0;
            overflow             <= 1'b0;
            bus.data_write_start <= 1'b0;
            bus.data_write_done  <= 1'b0;
        end else begin
            bus.data_write_start <= rd_en;
            if (first_word)         word_count <= CW'(1);
            else if (accept)        word_count <= count_inc;
            else if (release_frame) word_count <= '0;

            if (rd_en)              rd_ptr <= rd_ptr + 1'b1;
            else if (release_frame) rd_ptr <= '0;

            if (first_word) overflow <= 1'b0;
            else if (accept && !bus.host_last && (count_inc == FULL)) overflow <= 1'b1;

            if (stream_end)         bus.data_write_done <= 1'b1;
            else if (release_frame) bus.data_write_done <= 1'b0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          checksum <= '0;
        else if (first_word) checksum <= bus.host_data;
        else if (accept)     checksum <= checksum + bus.host_data;
    end
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_com_frame_loader.sv
// tb_com_frame_loader
//   Directed plus randomized frames against a queue-based model of the
//   loader; DUT built with DEPTH=8 so truncation is reachable.
module tb_com_frame_loader;
    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic [3:0]  word_count;
    logic        overflow;
    logic [1:0]  ld_state;
    logic [15:0] checksum;

    com_frame_loader_if bus();

    com_frame_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .word_count (word_count),
        .overflow   (overflow),
        .ld_state   (ld_state),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] frame_words[$];
    bit          frame_last;
    logic [15:0] carry[$];
    logic [15:0] exp_q[$];
    bit          exp_ovf;
    logic [15:0] exp_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ck(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return 16'h0000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers frame_words; the model accepts min(n, DEPTH) of them and leaves
    // the rest in carry, with the first leftover still presented as valid.
    task automatic send_frame();
        int n, exp_n;
        bit lst;
        n       = frame_words.size();
        exp_n   = (n > DEPTH) ? DEPTH : n;
        exp_ovf = (n > DEPTH) || ((n == DEPTH) && !frame_last);
        exp_q   = {};
        carry   = {};
        exp_sum = 16'h0000;
        for (int i = 0; i < n; i++) begin
            lst = frame_last && (i == n - 1);
            bus.host_data  = frame_words[i];
            bus.host_valid = 1'b1;
            bus.host_last  = lst;
            check("host_ready_offer", 32'(bus.host_ready), 32'(i < exp_n));
            if (i >= exp_n) begin
                for (int j = i; j < n; j++) carry.push_back(frame_words[j]);
                break;
            end
            exp_q.push_back(frame_words[i]);
            exp_sum = exp_sum + frame_words[i];
            step();
            check("word_count_fill", 32'(word_count), 32'(i + 1));
            check("overflow_fill", 32'(overflow), 32'((i + 1 == DEPTH) && !lst));
            check("ld_state_fill", 32'(ld_state), (i + 1 == exp_n) ? 32'd2 : 32'd1);
            check("checksum_fill", 32'(checksum), 32'(exp_ck(exp_sum)));
        end
        if (carry.size() == 0) begin
            bus.host_valid = 1'b0;
            bus.host_last  = 1'b0;
        end
    endtask

    // Entered in cycle T+1; returns in W+1 (back in IDLE).
    task automatic stream_and_release();
        int n;
        n = exp_q.size();
        check("dws_t1", 32'(bus.data_write_start), 32'd0);
        for (int k = 0; k < n; k++) begin
            step();
            check("dws_stream", 32'(bus.data_write_start), 32'd1);
            check("com_data_in", 32'(bus.com_data_in), 32'(exp_q[k]));
            check("ready_stream", 32'(bus.host_ready), 32'd0);
            bus.output_write_done = 1'($urandom_range(0, 1));
        end
        step();
        bus.output_write_done = 1'b0;
        check("dws_end", 32'(bus.data_write_start), 32'd0);
        check("dwd_set", 32'(bus.data_write_done), 32'd1);
        check("ld_state_wait", 32'(ld_state), 32'd3);
        check("data_hold", 32'(bus.com_data_in), 32'(exp_q[n-1]));
        check("word_count_wait", 32'(word_count), 32'(n));
        check("overflow_wait", 32'(overflow), 32'(exp_ovf));
        check("checksum_wait", 32'(checksum), 32'(exp_ck(exp_sum)));
        repeat ($urandom_range(0, 3)) begin
            step();
            check("dwd_hold", 32'(bus.data_write_done), 32'd1);
            check("wait_hold", 32'(ld_state), 32'd3);
        end
        bus.output_write_done = 1'b1;
        step();
        bus.output_write_done = 1'b0;
        check("ld_state_idle", 32'(ld_state), 32'd0);
        check("dwd_clear", 32'(bus.data_write_done), 32'd0);
        check("word_count_clear", 32'(word_count), 32'd0);
        check("ready_idle", 32'(bus.host_ready), 32'd1);
        check("overflow_hold", 32'(overflow), 32'(exp_ovf));
        check("checksum_hold", 32'(checksum), 32'(exp_ck(exp_sum)));
    endtask

    task automatic run_frame();
        send_frame();
        stream_and_release();
    endtask

    initial begin
        int len;
        rst_n                 = 1'b0;
        bus.host_data         = '0;
        bus.host_valid        = 1'b0;
        bus.host_last         = 1'b0;
        bus.output_write_done = 1'b0;
        #12;
        check("rst_state", 32'(ld_state), 32'd0);
        check("rst_ready", 32'(bus.host_ready), 32'd1);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_dws", 32'(bus.data_write_start), 32'd0);
        check("rst_dwd", 32'(bus.data_write_done), 32'd0);
        check("rst_data", 32'(bus.com_data_in), 32'd0);
        check("rst_ck", 32'(checksum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        frame_words = '{16'd1, 16'd2, 16'd3, 16'd4};
        frame_last  = 1'b1;
        run_frame();

        // 9 words, no last: 8 accepted, word 18 left pending through STREAM/WAIT.
        frame_words = {};
        for (int i = 10; i <= 18; i++) frame_words.push_back(16'(i));
        frame_last = 1'b0;
        run_frame();
        check("carry_size", 32'(carry.size()), 32'd1);

        // Pending word accepted in W+1 and clears overflow.
        frame_words = carry;
        frame_words.push_back(16'h1234);
        frame_last = 1'b1;
        run_frame();

        frame_words = '{16'hBEEF};
        frame_last  = 1'b1;
        run_frame();

        frame_words = '{16'hFFFF, 16'h0002};
        frame_last  = 1'b1;
        run_frame();
        check("checksum_wrap", 32'(checksum), 32'(exp_ck(16'h0001)));

        for (int f = 0; f < 8; f++) begin
            frame_words = carry;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) frame_words.push_back(16'($urandom));
            if (frame_words.size() < DEPTH) frame_last = 1'b1;
            else                             frame_last = 1'($urandom_range(0, 1));
            run_frame();
        end
        if (carry.size() != 0) begin
            frame_words = carry;
            frame_last  = 1'b1;
            run_frame();
        end

        // Reset in the middle of streaming an 8-word frame.
        frame_words = {};
        for (int i = 0; i < 8; i++) frame_words.push_back(16'(16'h0A00 + i));
        frame_last = 1'b1;
        send_frame();
        step();
        step();
        check("pre_rst_dws", 32'(bus.data_write_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dws", 32'(bus.data_write_start), 32'd0);
        check("midrst_state", 32'(ld_state), 32'd0);
        check("midrst_count", 32'(word_count), 32'd0);
        check("midrst_data", 32'(bus.com_data_in), 32'd0);
        check("midrst_ready", 32'(bus.host_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        frame_words = '{16'h5A5A, 16'hA5A5};
        frame_last  = 1'b1;
        run_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/com_frame_loader.md
# com_frame_loader

Host-side loader that sits directly upstream of the multi-core `main` block and drives its load port (`com_data_in`, `data_write_start`, `data_write_done`). It accepts a frame of 16-bit words from a host over a valid/ready stream and stores it in an internal buffer. Once the frame is complete, it replays the frame to the core at one word per cycle with no gaps, since the core has no stall input. It then holds the load-done indication until the core reports `output_write_done`.

## Interface
- `DEPTH`, 256: buffer capacity in words; power of two, 2 to 4096.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `host_data`  in  16  frame word from host.
- `host_valid`  in  1  `host_data` valid.
- `host_last`  in  1  qualifies the final word of a frame.
- `host_ready`  out  1  loader can accept a word. Combinational from state and count.
- `com_data_in`  out  16  word to core, registered.
- `data_write_start`  out  1  core load window, registered.
- `data_write_done`  out  1  frame fully delivered, registered.
- `output_write_done`  in  1  core has finished writing its results.
- `word_count`  out  $clog2(DEPTH+1)  number of words in the current frame.
- `overflow`  out  1  sticky; frame was truncated at DEPTH.
- `ld_state`  out  2  IDLE=00, FILL=01, STREAM=10, WAIT=11.
- `checksum`  out  16  frame checksum. Tied to 0 unless `LOADER_CHECKSUM_EN` is defined.

## Operation
- Reset values:
  - state IDLE.
  - `com_data_in`=0, `data_write_start`=0, `data_write_done`=0.
  - `word_count`=0, `overflow`=0, `checksum`=0.
  - write and read pointers 0.
  - `host_ready`=1, because it is derived from IDLE with count 0.
- Handshake: a word is accepted in a cycle where `host_valid` and `host_ready` are both 1.
- `host_ready`=1 only in IDLE or FILL, and only while `word_count` < DEPTH.
- IDLE:
  - First accepted word clears `overflow` and sets `word_count`=1.
  - Goes to FILL, or to STREAM if that word has `host_last`=1.
- FILL:
  - Each accept writes buffer[`word_count`] and increments `word_count`.
  - An accept with `host_last`=1 goes to STREAM.
  - An accept that makes `word_count`==DEPTH with `host_last`=0 sets `overflow`=1 and goes to STREAM. The frame is truncated.
- STREAM:
  - Reads buffer[0..N-1] in order, where N=`word_count`.
  - Presents each word on `com_data_in` with `data_write_start`=1.
  - After word N-1, goes to WAIT.
- WAIT:
  - `data_write_start`=0, `data_write_done`=1, `com_data_in` holds the last word.
  - When `output_write_done`=1 is sampled, goes to IDLE.
  - On that transition: `data_write_done`=0, `word_count`=0, pointers reset. `overflow` and `checksum` hold.
- `output_write_done` is ignored outside WAIT.
- Host words offered in STREAM or WAIT are not accepted, because `host_ready`=0. The host must hold them until the next IDLE.
- Reset asserted mid-operation returns all state and outputs to reset values immediately. Buffer contents are discarded; the core sees `data_write_start` drop asynchronously.
- Buffer is a single-port-per-side synchronous RAM with registered read, inferable as block RAM.

## Timing
- If the frame-completing accept happens in cycle T:
  - `ld_state`=STREAM from T+1.
  - Word k is on `com_data_in` with `data_write_start`=1 in cycle T+2+k, for k=0..N-1.
  - `data_write_start` is high for exactly N consecutive cycles.
  - `data_write_done`=1 from T+N+2.
- If `output_write_done` is sampled high in cycle W (state WAIT): `data_write_done`=0 and `ld_state`=IDLE in W+1, and `host_ready`=1 in W+1.
- Minimum frame-to-frame turnaround: the next frame's first accept can occur in W+1.
- Single-word frame (N=1): one cycle of `data_write_start`, in T+2. `data_write_done` from T+3.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - `checksum` is the modulo-2^16 sum of all accepted words of the current frame.
  - Cleared on the first accept of a new frame; updated on each accept; stable from T+1 until the next frame starts.
- `LOADER_CHECKSUM_EN` undefined: `checksum` is constant 0 and no adder is synthesized.

## Test plan
- 4-word frame 0x0001, 0x0002, 0x0003, 0x0004, with `host_last` on the 4th word at cycle T.
  - `com_data_in` = 1, 2, 3, 4 at T+2..T+5 with `data_write_start`=1.
  - `data_write_done`=1 at T+6.
  - Pulse `output_write_done` → IDLE next cycle, `word_count`=0.
- DEPTH=8; host sends 9 words 10..18 with no `host_last`.
  - Exactly 8 words are accepted, then `host_ready`=0.
  - `overflow`=1.
  - `com_data_in` = 10..17 over 8 cycles; word 18 is still pending at the host.
- `host_valid` held high through STREAM and WAIT.
  - No accepts occur.
  - After the `output_write_done` pulse, the pending word is accepted in W+1 and clears `overflow`.
- Single-word frame 0xBEEF with `host_last`=1 from IDLE.
  - `data_write_start` is high for one cycle with `com_data_in`=0xBEEF.
  - `data_write_done` is high the next cycle.
- Assert `rst_n`=0 during STREAM of an 8-word frame.
  - `data_write_start`=0, `ld_state`=00, `word_count`=0 immediately.
  - A new 2-word frame then streams correctly.
- With `LOADER_CHECKSUM_EN` defined, frame 0xFFFF, 0x0002 → `checksum`=0x0001.
